// File: rtl/disp_arbiter.sv
// ============================================================================
// disp_arbiter : round-robin owner arbitration for a shared 4-digit display
// Revision     : 1.0
// ============================================================================
`default_nettype none

module disp_arbiter #(
  parameter int HOLD_CYCLES = 1000,
  parameter int SCAN_DIV    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] num0,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  input  logic [15:0] num3,
  input  logic        lock,
  output logic [15:0] num_out,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        blank,
  output logic        scan_tick
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [HW-1:0] c_hold_load = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] c_presc_max = PW'(SCAN_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    last_owner_q, last_owner_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]    owner_q, owner_d;
  logic [3:0]    grant_q, grant_d;
  logic          blank_q, blank_d;
  logic [15:0]   num_out_q, num_out_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          scan_tick_q, scan_tick_d;

  logic [2:0]    pick_any;    // {valid, index} over all requesters
  logic [2:0]    pick_other;  // {valid, index} excluding the current owner

  // Search starts at last+1 and wraps; last itself is tried last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [15:0] num_sel(input logic [1:0] idx,
                                          input logic [15:0] n0, input logic [15:0] n1,
                                          input logic [15:0] n2, input logic [15:0] n3);
    logic [15:0] v;
    case (idx)
      2'd0:    v = n0;
      2'd1:    v = n1;
      2'd2:    v = n2;
      default: v = n3;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    blank_d      = blank_q;
    num_out_d    = num_out_q;
    pick_any     = rr_pick(req, last_owner_q);
    pick_other   = rr_pick(req & ~(4'b0001 << owner_q), owner_q);

    case (state_q)
      IDLE: begin
        blank_d = 1'b1;
        grant_d = 4'b0000;
        if (pick_any[2]) begin
          state_d      = SHOW;
          owner_d      = pick_any[1:0];
          grant_d      = 4'b0001 << pick_any[1:0];
          blank_d      = 1'b0;
          num_out_d    = num_sel(pick_any[1:0], num0, num1, num2, num3);
          hold_cnt_d   = c_hold_load;
          last_owner_d = pick_any[1:0];
        end
      end
      SHOW: begin
        if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HW'(1);
        if (req[owner_q]) num_out_d = num_sel(owner_q, num0, num1, num2, num3);
        if ((hold_cnt_q == '0) && !lock) begin
          if (pick_other[2]) begin
            owner_d      = pick_other[1:0];
            grant_d      = 4'b0001 << pick_other[1:0];
            num_out_d    = num_sel(pick_other[1:0], num0, num1, num2, num3);
            hold_cnt_d   = c_hold_load;
            last_owner_d = pick_other[1:0];
          end else if (!req[owner_q]) begin
            state_d = IDLE;
            blank_d = 1'b1;
            grant_d = 4'b0000;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan prescaler runs regardless of arbitration state.
  always_comb begin
    presc_d     = (presc_q == c_presc_max) ? '0 : presc_q + PW'(1);
    scan_tick_d = (presc_q == c_presc_max);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 2'd3;
      hold_cnt_q   <= '0;
      owner_q      <= 2'd0;
      grant_q      <= 4'b0000;
      blank_q      <= 1'b1;
      num_out_q    <= 16'h0000;
      presc_q      <= '0;
      scan_tick_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      blank_q      <= blank_d;
      num_out_q    <= num_out_d;
      presc_q      <= presc_d;
      scan_tick_q  <= scan_tick_d;
    end
  end

  assign num_out   = num_out_q;
  assign grant     = grant_q;
  assign owner     = owner_q;
  assign blank     = blank_q;
  assign scan_tick = scan_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_arbiter.sv
// ============================================================================
// tb_disp_arbiter : directed vector bench for disp_arbiter (HOLD 4 and HOLD 1)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic        lock = 1'b0;
  logic [15:0] num0 = 16'h1234;
  logic [15:0] num1 = 16'h0011;
  logic [15:0] num2 = 16'hABCD;
  logic [15:0] num3 = 16'h5678;

  logic [15:0] a_num_out, b_num_out;
  logic [3:0]  a_grant, b_grant;
  logic [1:0]  a_owner, b_owner;
  logic        a_blank, b_blank, a_tick, b_tick;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  disp_arbiter #(.HOLD_CYCLES(4), .SCAN_DIV(5)) dut_a (
    .clk(clk), .rst(rst), .req(req), .num0(num0), .num1(num1), .num2(num2), .num3(num3),
    .lock(lock), .num_out(a_num_out), .grant(a_grant), .owner(a_owner), .blank(a_blank),
    .scan_tick(a_tick)
  );

  disp_arbiter #(.HOLD_CYCLES(1), .SCAN_DIV(5)) dut_b (
    .clk(clk), .rst(rst), .req(req), .num0(num0), .num1(num1), .num2(num2), .num3(num3),
    .lock(lock), .num_out(b_num_out), .grant(b_grant), .owner(b_owner), .blank(b_blank),
    .scan_tick(b_tick)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        lock;
    logic [15:0] n1;
    logic [3:0]  g;
    logic [1:0]  o;
    logic        b;
    logic [15:0] nout;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic lk, input logic [15:0] n1,
                     input logic [3:0] g, input logic [1:0] o, input logic b, input logic [15:0] nout);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.n1 = n1;
    v.g = g; v.o = o; v.b = b; v.nout = nout;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [3:0] rot [0:4];

  initial begin
    // Round robin with hold, then idle
    add(1, 4'b0000, 0, 16'h0011, 4'b0000, 0, 1, 16'h0000);
    add(0, 4'b0000, 0, 16'h0011, 4'b0000, 0, 1, 16'h0000);
    for (int i = 0; i < 4; i++) add(0, 4'b0101, 0, 16'h0011, 4'b0001, 0, 0, 16'h1234);
    for (int i = 0; i < 4; i++) add(0, 4'b0101, 0, 16'h0011, 4'b0100, 2, 0, 16'hABCD);
    add(0, 4'b0101, 0, 16'h0011, 4'b0001, 0, 0, 16'h1234);
    for (int i = 0; i < 3; i++) add(0, 4'b0000, 0, 16'h0011, 4'b0001, 0, 0, 16'h1234);
    add(0, 4'b0000, 0, 16'h0011, 4'b0000, 0, 1, 16'h1234);
    // Value tracking, owner drops early, frozen until expiry
    add(0, 4'b0010, 0, 16'h0011, 4'b0010, 1, 0, 16'h0011);
    add(0, 4'b0010, 0, 16'h0022, 4'b0010, 1, 0, 16'h0022);
    add(0, 4'b0000, 0, 16'h0033, 4'b0010, 1, 0, 16'h0022);
    add(0, 4'b0000, 0, 16'h0033, 4'b0010, 1, 0, 16'h0022);
    add(0, 4'b0000, 0, 16'h0033, 4'b0000, 1, 1, 16'h0022);
    // Lock ignored in IDLE, then freezes owner 0 against req=1111
    add(0, 4'b0001, 1, 16'h0033, 4'b0001, 0, 0, 16'h1234);
    for (int i = 0; i < 10; i++) add(0, 4'b1111, 1, 16'h0033, 4'b0001, 0, 0, 16'h1234);
    add(0, 4'b1111, 0, 16'h0033, 4'b0010, 1, 0, 16'h0033);
    // Reach owner 2, reset, restart from initial order
    for (int i = 0; i < 3; i++) add(0, 4'b0100, 0, 16'h0033, 4'b0010, 1, 0, 16'h0033);
    add(0, 4'b0100, 0, 16'h0033, 4'b0100, 2, 0, 16'hABCD);
    add(1, 4'b1100, 0, 16'h0033, 4'b0000, 0, 1, 16'h0000);
    add(0, 4'b1100, 0, 16'h0033, 4'b0100, 2, 0, 16'hABCD);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      rst = vq[k].rst; req = vq[k].req; lock = vq[k].lock; num1 = vq[k].n1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d grant", k), 32'(a_grant), 32'(vq[k].g));
      chk($sformatf("v%0d owner", k), 32'(a_owner), 32'(vq[k].o));
      chk($sformatf("v%0d blank", k), 32'(a_blank), 32'(vq[k].b));
      chk($sformatf("v%0d num_out", k), 32'(a_num_out), 32'(vq[k].nout));
    end

    // Reset asserted mid-cycle while owner 2 holds the display
    @(negedge clk);
    rst = 1'b1; req = 4'b0000;
    #1;
    chk("async_rst grant", 32'(a_grant), 32'h0);
    chk("async_rst owner", 32'(a_owner), 32'h0);
    chk("async_rst blank", 32'(a_blank), 32'h1);
    chk("async_rst num_out", 32'(a_num_out), 32'h0);
    chk("async_rst tick", 32'(a_tick), 32'h0);

    // Idle after release: blank, no grant, scan_tick every 5th cycle
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d tick", k), 32'(a_tick), 32'((k % 5) == 0));
      chk($sformatf("idle%0d blank", k), 32'(a_blank), 32'h1);
      chk($sformatf("idle%0d grant", k), 32'(a_grant), 32'h0);
      chk($sformatf("idle%0d num_out", k), 32'(a_num_out), 32'h0);
    end

    // HOLD_CYCLES=1: rotation every cycle
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;
    @(negedge clk);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rot%0d grant", k), 32'(b_grant), 32'(rot[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000; minimum clk cycles one requester owns the display once granted; legal range >= 1.
REQ-002 Parameter SCAN_DIV, default 50000; clk cycles per scan_tick period; legal range >= 2.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  4  per-requester display request; bit i belongs to requester i.
REQ-006 num0, num1, num2, num3  input  16 each  value requester i wants displayed, as 4 hex digits.
REQ-007 lock  input  1  freezes the current owner while high.
REQ-008 num_out  output  16  registered value driven to the 4-digit display driver.
REQ-009 grant  output  4  registered one-hot current owner; all-zero when no owner.
REQ-010 owner  output  2  registered binary index of the current owner.
REQ-011 blank  output  1  registered; 1 = no owner, so the display shows nothing.
REQ-012 scan_tick  output  1  registered one-cycle digit-advance strobe for the display driver.

Function
REQ-013 FSM states are IDLE and SHOW; all outputs are registered.
REQ-014 Round-robin arbitration: search order starts at (last_owner+1) mod 4 and wraps; last_owner resets to 3, so the first search order is 0,1,2,3.
REQ-015 IDLE with req != 0: the edge that samples req enters SHOW, sets owner/grant to the winner, clears blank, loads num_out with the winner's num and loads hold_cnt with HOLD_CYCLES-1; output latency is 1 cycle from req.
REQ-016 IDLE with req == 0: stay in IDLE; blank=1, grant=0; owner and num_out hold their last values.
REQ-017 SHOW: num_out <= num[owner] every cycle while req[owner]=1; while req[owner]=0, num_out freezes at its last value.
REQ-018 SHOW: hold_cnt decrements by 1 per cycle down to 0 and saturates there; it is independent of lock.
REQ-019 SHOW, hold_cnt=0, lock=0, and some req[j]=1 with j != owner: on that edge, switch to the round-robin winner among requesters other than the owner; reload hold_cnt; update last_owner; num_out takes the new owner's num.
REQ-020 SHOW, hold_cnt=0, lock=0, only req[owner]=1: stay in SHOW; hold_cnt stays 0, so a later request from another requester switches on the edge that samples it.
REQ-021 SHOW, hold_cnt=0, lock=0, req=0: go to IDLE; blank=1, grant=0 on the next cycle.
REQ-022 lock=1 in SHOW: no owner change and no move to IDLE; evaluation of REQ-019..021 resumes on the first edge with lock=0.
REQ-023 lock has no effect in IDLE.
REQ-024 Simultaneous requests are resolved only by REQ-014 order; there is no fixed priority.
REQ-025 Owner dropping req before hold expiry does not shorten the hold: the display keeps the frozen value until hold_cnt=0.
REQ-026 HOLD_CYCLES=1: the hold expires on the cycle after the grant, so a switch is possible every cycle.
REQ-027 Prescaler: free-running counter 0..SCAN_DIV-1, wraps to 0; scan_tick=1 exactly on the cycle after the counter holds SCAN_DIV-1; unaffected by FSM state.
REQ-028 Widths: hold_cnt is clog2(HOLD_CYCLES+1) bits and the prescaler is clog2(SCAN_DIV) bits; neither may overflow.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, num_out=16'h0000, grant=4'b0000, owner=2'd0, blank=1, scan_tick=0, prescaler=0, hold_cnt=0, last_owner=3.
REQ-030 Reset asserted mid-SHOW aborts the grant immediately; after release, arbitration restarts from the REQ-014 initial order.

Verification (HOLD_CYCLES=4, SCAN_DIV=5)
REQ-031 Reset release, req=0 for 12 cycles -> blank=1, grant=0000, num_out=0000; scan_tick pulses every 5th cycle, 1 cycle wide.
REQ-032 req=0101 set at edge 0, num0=1234, num2=ABCD held -> from cycle 1 grant=0001, num_out=1234; switch to grant=0100, num_out=ABCD 4 cycles later; 4 cycles after that, back to 0001.
REQ-033 req=0010, num1 changes 0011->0022 mid-grant -> num_out follows with 1-cycle lag; req drops at hold_cnt=2 -> num_out frozen at 0022, then IDLE/blank=1 after expiry.
REQ-034 Owner 0 granted, lock=1 for 10 cycles, req=1111 -> grant stays 0001 throughout; 1 cycle after lock falls, grant=0010.
REQ-035 rst pulsed while grant=0100 -> outputs take REQ-029 values immediately; with req=1100 after release, the first grant is 0100.
REQ-036 HOLD_CYCLES=1 build, req=1111 steady -> grant rotates 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
